// File: rtl/regfile_wb_sequencer.sv
// Register-file write-port sequencer: merges unbackpressured ALU results with
// FIFO-buffered LSU loads into one registered write per cycle.
module regfile_wb_sequencer #(
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        alu_valid_i,
    input  logic [4:0]  alu_rd_addr_i,
    input  logic [31:0] alu_data_i,
    output logic        alu_stall_o,
    input  logic        lsu_valid_i,
    output logic        lsu_ready_o,
    input  logic [4:0]  lsu_rd_addr_i,
    input  logic [31:0] lsu_data_i,
    input  logic [4:0]  hz_addr_i,
    output logic        hz_pending_o,
    output logic [4:0]  rd_addr_o,
    output logic [31:0] rd_data_o,
    output logic        rd_wren_o,
    output logic        drop_err_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    typedef enum logic [0:0] {
        ST_NORMAL = 1'b0,
        ST_FORCE  = 1'b1
    } state_e;

    state_e          state_r;
    state_e          state_nxt_s;
    logic            alu_stall_r;
    logic            drop_err_r;
    logic            rd_wren_r;
    logic [4:0]      rd_addr_r;
    logic [31:0]     rd_data_r;
    logic [AW-1:0]   head_r;
    logic [AW-1:0]   tail_r;
    logic [CW-1:0]   count_r;
    logic [CW-1:0]   count_nxt_s;
    logic [SW-1:0]   starve_r;
    logic [SW-1:0]   starve_nxt_s;
    logic [4:0]      fifo_addr_r [DEPTH];
    logic [31:0]     fifo_data_r [DEPTH];

    logic            full_s;
    logic            empty_s;
    logic            push_s;
    logic            pop_s;
    logic            alu_win_s;
    logic            hz_match_s;
    logic [AW-1:0]   hz_off_s;

    // Write-select, occupancy, starvation counter and next-state decisions.
    always_comb begin
        full_s      = (count_r == CW'(DEPTH));
        empty_s     = (count_r == {CW{1'b0}});
        push_s      = lsu_valid_i & ~full_s & (lsu_rd_addr_i != 5'd0);
        alu_win_s   = (state_r == ST_NORMAL) & alu_valid_i & ~alu_stall_r
                      & (alu_rd_addr_i != 5'd0);
        pop_s       = ~alu_win_s & ~empty_s;
        count_nxt_s = count_r;
        case ({push_s, pop_s})
            2'b10:   count_nxt_s = count_r + CW'(1);
            2'b01:   count_nxt_s = count_r - CW'(1);
            default: count_nxt_s = count_r;
        endcase
        starve_nxt_s = starve_r;
        if (pop_s || empty_s) begin
            starve_nxt_s = {SW{1'b0}};
        end else if (alu_win_s) begin
            starve_nxt_s = starve_r + SW'(1);
        end else begin
            starve_nxt_s = starve_r;
        end
        state_nxt_s = state_r;
        case (state_r)
            ST_NORMAL: begin
                if (starve_nxt_s == SW'(STARVE_LIMIT)) begin
                    state_nxt_s = ST_FORCE;
                end else begin
                    state_nxt_s = ST_NORMAL;
                end
            end
            ST_FORCE: begin
                if (count_nxt_s == {CW{1'b0}}) begin
                    state_nxt_s = ST_NORMAL;
                end else begin
                    state_nxt_s = ST_FORCE;
                end
            end
            default: state_nxt_s = ST_NORMAL;
        endcase
    end

    // Hazard lookup: entry validity is its distance from head versus occupancy.
    always_comb begin
        hz_match_s = 1'b0;
        hz_off_s   = {AW{1'b0}};
        for (int i = 0; i < DEPTH; i++) begin
            hz_off_s = AW'(i) - head_r;
            if (({1'b0, hz_off_s} < count_r) && (fifo_addr_r[i] == hz_addr_i)) begin
                hz_match_s = 1'b1;
            end else begin
                hz_match_s = hz_match_s;
            end
        end
    end

    // FIFO storage; contents need no reset since validity comes from count_r.
    always_ff @(posedge clk_i) begin
        if (push_s) begin
            fifo_addr_r[tail_r] <= lsu_rd_addr_i;
            fifo_data_r[tail_r] <= lsu_data_i;
        end
    end

    // Control state, pointers and the registered write port.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r     <= ST_NORMAL;
            alu_stall_r <= 1'b0;
            drop_err_r  <= 1'b0;
            rd_wren_r   <= 1'b0;
            rd_addr_r   <= 5'd0;
            rd_data_r   <= 32'd0;
            head_r      <= {AW{1'b0}};
            tail_r      <= {AW{1'b0}};
            count_r     <= {CW{1'b0}};
            starve_r    <= {SW{1'b0}};
        end else begin
            state_r     <= state_nxt_s;
            alu_stall_r <= (state_nxt_s == ST_FORCE);
            count_r     <= count_nxt_s;
            starve_r    <= starve_nxt_s;
            if (alu_valid_i && alu_stall_r) begin
                drop_err_r <= 1'b1;
            end
            if (push_s) begin
                tail_r <= tail_r + AW'(1);
            end
            if (alu_win_s) begin
                rd_wren_r <= 1'b1;
                rd_addr_r <= alu_rd_addr_i;
                rd_data_r <= alu_data_i;
            end else if (pop_s) begin
                rd_wren_r <= 1'b1;
                rd_addr_r <= fifo_addr_r[head_r];
                rd_data_r <= fifo_data_r[head_r];
                head_r    <= head_r + AW'(1);
            end else begin
                rd_wren_r <= 1'b0;
            end
        end
    end

    assign alu_stall_o  = alu_stall_r;
    assign drop_err_o   = drop_err_r;
    assign rd_wren_o    = rd_wren_r;
    assign rd_addr_o    = rd_addr_r;
    assign rd_data_o    = rd_data_r;
    assign lsu_ready_o  = ~full_s;
    assign hz_pending_o = (hz_addr_i != 5'd0)
                          & (hz_match_s | (rd_wren_r & (rd_addr_r == hz_addr_i)));

endmodule

// File: doc/regfile_wb_sequencer.md
Name: regfile_wb_sequencer

Overview:
- Writer side of the register file's single write port (rd_addr / rd_data / rd_wren).
- Merges two result sources into one registered write per cycle:
  - single-cycle ALU results, which have no backpressure;
  - multi-cycle LSU load results, which use a valid/ready handshake and are buffered in a small FIFO.
- Provides a pending-write query so decode can detect RAW hazards on buffered loads.
- Prevents LSU starvation by forcing an ALU stall cycle.

Parameters:
- DEPTH, 4, LSU FIFO entries; power of 2, at least 2.
- STARVE_LIMIT, 8, consecutive ALU-won cycles with FIFO non-empty before a forced drain.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  synchronous reset, active-high.
- alu_valid_i  in  1  ALU result present this cycle.
- alu_rd_addr_i  in  5  ALU destination register.
- alu_data_i  in  32  ALU result.
- alu_stall_o  out  1  registered; upstream must hold alu_valid_i low while this is 1.
- lsu_valid_i  in  1  load result offered.
- lsu_ready_o  out  1  block can accept a load result; equals !full.
- lsu_rd_addr_i  in  5  load destination register.
- lsu_data_i  in  32  load data.
- hz_addr_i  in  5  decode query address.
- hz_pending_o  out  1  combinational; a write to hz_addr_i is in flight.
- rd_addr_o  out  5  register file write address, registered.
- rd_data_o  out  32  register file write data, registered.
- rd_wren_o  out  1  register file write enable, registered.
- drop_err_o  out  1  sticky protocol-violation flag.

Behaviour:
- Reset (rst_i=1 at an edge) clears everything, with no partial drains:
  - rd_wren_o=0, rd_addr_o=0, rd_data_o=0;
  - alu_stall_o=0, drop_err_o=0;
  - FIFO empty, so lsu_ready_o=1;
  - starve counter=0, FSM returns to NORMAL.
  - Reset mid-operation discards all queued loads.
- Enqueue: at an edge where lsu_valid_i & lsu_ready_o & (lsu_rd_addr_i!=0), write the FIFO tail.
  - Handshakes addressed to x0 complete but are discarded.
  - lsu_ready_o depends only on full. There is no same-cycle pass-through when full, even if a pop occurs in that cycle.
- Write select, evaluated each cycle; the output register loads at the edge:
  1. NORMAL state with alu_valid_i=1 and alu_rd_addr_i!=0: load the ALU write.
  2. Otherwise, if the FIFO is non-empty: pop the head and load it.
  3. Otherwise: rd_wren_o=0, and rd_addr_o / rd_data_o hold their previous values.
  - ALU results to x0 never assert rd_wren_o. They do not block a FIFO pop.
- Latency:
  - ALU valid in cycle N gives rd_wren_o=1 in cycle N+1.
  - LSU accepted at the end of cycle N is at the head in N+1. With no ALU contention it is written in cycle N+2.
- FIFO order: strict FIFO. Simultaneous push and pop when not full are legal, and the count is unchanged.
- FSM states and transitions:
  - NORMAL → FORCE when the starve counter reaches STARVE_LIMIT.
    - The counter increments on each cycle where the FIFO is non-empty and the ALU won select.
    - It clears on any pop, or when the FIFO is empty.
  - FORCE: alu_stall_o=1 (registered, asserted the cycle after the transition); the FIFO pops every cycle.
  - FORCE → NORMAL at the edge where the FIFO becomes empty. alu_stall_o drops in the following cycle.
- Violation handling: alu_valid_i=1 while alu_stall_o=1 drops that ALU result and sets drop_err_o. drop_err_o stays set until reset.
- hz_pending_o = (hz_addr_i!=0) & (any valid FIFO entry has matching rd_addr, or rd_wren_o & rd_addr_o==hz_addr_i).
  - Purely combinational.
  - Matches are counted for wrapped pointers too; validity comes from the occupancy count, not the raw index.
- Pointers: wrap modulo DEPTH. Count width is log2(DEPTH)+1, so full and empty are distinguishable.

Test Plan:
1. Reset, then ALU write x5=0x1234 in cycle 1 → cycle 2: rd_wren_o=1, rd_addr_o=5, rd_data_o=0x1234; cycle 3: rd_wren_o=0.
2. Lone LSU load x7=0xDEADBEEF accepted at cycle 1, no ALU traffic → rd_wren_o=1 with addr 7 in cycle 3. hz_addr_i=7 gives hz_pending_o=1 in cycles 2–3, and 0 in cycle 4.
3. Push 4 loads (x1..x4) while the ALU is busy every cycle → lsu_ready_o=0 after the 4th. Release the ALU → writes appear in order x1, x2, x3, x4 on consecutive cycles; lsu_ready_o returns to 1 after the first pop.
4. One queued load plus continuous ALU traffic → after 8 ALU-won cycles alu_stall_o=1; the load is written; alu_stall_o=0 the cycle after the FIFO empties.
5. ALU rd=x0 and LSU rd=x0 in the same cycle → no rd_wren_o, FIFO count stays 0. Separately, alu_valid_i during alu_stall_o → drop_err_o=1 and remains set until rst_i.
6. Assert rst_i with 3 loads queued and rd_wren_o=1 → next cycle: all outputs zero, lsu_ready_o=1, hz_pending_o=0 for x1..x31.
